// File: rtl/ds_rx_pkg.sv
// Shared types for the differential receiver: FSM states, decoded-sample
// record and the pure P/N decode function.
package ds_rx_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } ds_state_e;

  typedef struct packed {
    logic valid;
    logic value;
  } ds_dec_t;

  // (1,0) -> 1, (0,1) -> 0, equal pins -> invalid
  function automatic ds_dec_t ds_decode(input logic p, input logic n);
    ds_dec_t d;
    d.valid = p ^ n;
    d.value = p;
    return d;
  endfunction

endpackage

// File: rtl/ds_rx_sync.sv
// Two-bit multi-stage synchroniser for the asynchronous P/N pin pair.
// Every stage clears to 0 on reset.
module ds_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  logic [STAGES-1:0][1:0] stage_q;

  // shift chain; stage 0 is the only flop that sees the raw pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/i_buf_ds_rx.sv
// Differential input receiver: synchronise, decode, glitch-filter, fault-detect.
// Optional invalid-sample statistics counter: define I_BUF_DS_RX_STATS_EN.
module i_buf_ds_rx
  import ds_rx_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_DEPTH  = 3,
  parameter int SETTLE_CYCLES = 8,
  parameter int FAULT_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        i_p,
  input  logic        i_n,
  output logic        o,
  output logic        o_valid,
  output logic        o_rise,
  output logic        o_fall,
  output logic        fault,
  output logic [15:0] inv_cnt
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int FW = $clog2(FILTER_DEPTH + 1);
  localparam int XW = $clog2(FAULT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0] FILT_FULL   = FW'(FILTER_DEPTH);
  localparam logic [XW-1:0] BAD_FULL    = XW'(FAULT_CYCLES);

  logic [1:0] pins_sync;
  ds_dec_t    dec;

  ds_state_e     state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d, filt_run;
  logic          filt_val_q, filt_val_d;
  logic [XW-1:0] bad_q, bad_d, bad_run;
  logic          filt_full;
  logic          o_q, o_d;
  logic          valid_q, valid_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          fault_q, fault_d;

  ds_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({i_p, i_n}),
    .q_o   (pins_sync)
  );

  assign dec = ds_decode(pins_sync[1], pins_sync[0]);

  // Run lengths including the current sample. In RUN only values differing
  // from o count; elsewhere any run of identical valid values counts.
  always_comb begin
    filt_run = '0;
    if (!dec.valid) begin
      filt_run = '0;
    end else if ((state_q == ST_RUN) && (dec.value == o_q)) begin
      filt_run = '0;
    end else if ((filt_cnt_q != '0) && (dec.value == filt_val_q)) begin
      filt_run = (filt_cnt_q == FILT_FULL) ? filt_cnt_q : filt_cnt_q + FW'(1);
    end else begin
      filt_run = FW'(1);
    end
    filt_full = (filt_run == FILT_FULL);

    bad_run = '0;
    if (!dec.valid) begin
      bad_run = (bad_q == BAD_FULL) ? bad_q : bad_q + XW'(1);
    end else begin
      bad_run = '0;
    end
  end

  // next-state and registered-output logic; en low overrides everything
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    filt_cnt_d = filt_run;
    filt_val_d = dec.valid ? dec.value : filt_val_q;
    bad_d      = bad_run;
    o_d        = o_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;

    case (state_q)
      ST_OFF: begin
        settle_d   = '0;
        filt_cnt_d = '0;
        filt_val_d = 1'b0;
        bad_d      = '0;
        o_d        = 1'b0;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d    = ST_RUN;
          settle_d   = '0;
          filt_cnt_d = '0;
          o_d        = filt_full ? dec.value : 1'b0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_RUN: begin
        if (bad_run == BAD_FULL) begin
          state_d = ST_FAULT;
        end else if (filt_full) begin
          o_d        = dec.value;
          rise_d     = dec.value & ~o_q;
          fall_d     = ~dec.value & o_q;
          filt_cnt_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (filt_full) begin
          state_d    = ST_RUN;
          o_d        = dec.value;
          rise_d     = dec.value & ~o_q;
          fall_d     = ~dec.value & o_q;
          filt_cnt_d = '0;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    if (!en) begin
      state_d    = ST_OFF;
      settle_d   = '0;
      filt_cnt_d = '0;
      filt_val_d = 1'b0;
      bad_d      = '0;
      o_d        = 1'b0;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
    end else begin
      state_d = state_d;
    end

    valid_d = (state_d == ST_RUN);
    fault_d = (state_d == ST_FAULT);
  end

  // state, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      settle_q   <= '0;
      filt_cnt_q <= '0;
      filt_val_q <= 1'b0;
      bad_q      <= '0;
      o_q        <= 1'b0;
      valid_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      filt_cnt_q <= filt_cnt_d;
      filt_val_q <= filt_val_d;
      bad_q      <= bad_d;
      o_q        <= o_d;
      valid_q    <= valid_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      fault_q    <= fault_d;
    end
  end

  assign o       = o_q;
  assign o_valid = valid_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  assign fault   = fault_q;

`ifdef I_BUF_DS_RX_STATS_EN
  logic [15:0] inv_cnt_q, inv_cnt_d;

  // saturating count of invalid samples while the receiver is active
  always_comb begin
    inv_cnt_d = inv_cnt_q;
    if (!en || (state_q == ST_OFF)) begin
      inv_cnt_d = 16'h0000;
    end else if (!dec.valid && (inv_cnt_q != 16'hFFFF)) begin
      inv_cnt_d = inv_cnt_q + 16'h0001;
    end else begin
      inv_cnt_d = inv_cnt_q;
    end
  end

  // statistics register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_cnt_q <= 16'h0000;
    end else begin
      inv_cnt_q <= inv_cnt_d;
    end
  end

  assign inv_cnt = inv_cnt_q;
`else
  assign inv_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_i_buf_ds_rx.sv
// Self-checking bench for i_buf_ds_rx: per-edge expectation table fed through
// a scoreboard queue, plus hand-written async-reset and statistics sequences.
module tb_i_buf_ds_rx;

  logic        clk = 1'b0;
  logic        rst_n, en, i_p, i_n;
  logic        o, o_valid, o_rise, o_fall, fault;
  logic [15:0] inv_cnt;

  always #5 clk = ~clk;

  i_buf_ds_rx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .i_p     (i_p),
    .i_n     (i_n),
    .o       (o),
    .o_valid (o_valid),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .fault   (fault),
    .inv_cnt (inv_cnt)
  );

`ifdef I_BUF_DS_RX_STATS_EN
  localparam logic [15:0] EXP_INV = 16'd10;
`else
  localparam logic [15:0] EXP_INV = 16'd0;
`endif

  // exp = {o, o_valid, o_rise, o_fall, fault}, held for cnt edges
  typedef struct {
    logic       en;
    logic       p;
    logic       n;
    int         cnt;
    logic [4:0] exp;
  } row_t;

  row_t       rows[$];
  logic [4:0] sb[$];
  int         tests = 0;
  int         fails = 0;

  wire [4:0] outs = {o, o_valid, o_rise, o_fall, fault};

  task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: {o,valid,rise,fall,fault} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: inv_cnt got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic p, input logic n, input int c, input logic [4:0] x);
    row_t r;
    r.en = e; r.p = p; r.n = n; r.cnt = c; r.exp = x;
    rows.push_back(r);
  endtask

  task automatic apply_rows(input string tag);
    logic [4:0] want;
    for (int r = 0; r < rows.size(); r++) begin
      for (int k = 0; k < rows[r].cnt; k++) begin
        @(negedge clk);
        en  = rows[r].en;
        i_p = rows[r].p;
        i_n = rows[r].n;
        sb.push_back(rows[r].exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL %s: scoreboard empty", tag);
        end else begin
          want = sb.pop_front();
          check5($sformatf("%s row%0d edge%0d", tag, r, k), outs, want);
        end
      end
    end
    rows.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; i_p = 1'b0; i_n = 1'b0;
    #12;
    check5("reset outputs", outs, 5'b00000);
    check16("reset inv_cnt", inv_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // settle with (1,0): o loaded at RUN entry without a rise pulse
    add(1'b1, 1'b1, 1'b0, 8, 5'b00000);
    add(1'b1, 1'b1, 1'b0, 1, 5'b11000);
    add(1'b1, 1'b1, 1'b0, 2, 5'b11000);
    // fall after 5 edges, then rise back
    add(1'b1, 1'b0, 1'b1, 4, 5'b11000);
    add(1'b1, 1'b0, 1'b1, 1, 5'b01010);
    add(1'b1, 1'b0, 1'b1, 2, 5'b01000);
    add(1'b1, 1'b1, 1'b0, 4, 5'b01000);
    add(1'b1, 1'b1, 1'b0, 1, 5'b11100);
    add(1'b1, 1'b1, 1'b0, 2, 5'b11000);
    // 2-cycle glitch is filtered out
    add(1'b1, 1'b0, 1'b1, 2, 5'b11000);
    add(1'b1, 1'b1, 1'b0, 6, 5'b11000);
    // three invalid samples: one short of a fault
    add(1'b1, 1'b1, 1'b1, 3, 5'b11000);
    add(1'b1, 1'b1, 1'b0, 6, 5'b11000);
    // sustained invalid: fault after 6 edges, recover to 0 with o_fall
    add(1'b1, 1'b1, 1'b1, 5, 5'b11000);
    add(1'b1, 1'b1, 1'b1, 3, 5'b10001);
    add(1'b1, 1'b0, 1'b1, 4, 5'b10001);
    add(1'b1, 1'b0, 1'b1, 1, 5'b01010);
    add(1'b1, 1'b0, 1'b1, 2, 5'b01000);
    add(1'b1, 1'b1, 1'b0, 4, 5'b01000);
    add(1'b1, 1'b1, 1'b0, 1, 5'b11100);
    // en dropped while in FAULT, then full re-settle
    add(1'b1, 1'b1, 1'b1, 5, 5'b11000);
    add(1'b1, 1'b1, 1'b1, 2, 5'b10001);
    add(1'b0, 1'b1, 1'b1, 2, 5'b00000);
    add(1'b1, 1'b1, 1'b0, 8, 5'b00000);
    add(1'b1, 1'b1, 1'b0, 1, 5'b11000);
    // en dropped during a pending filter run; re-settle loads o=0
    add(1'b1, 1'b0, 1'b1, 3, 5'b11000);
    add(1'b0, 1'b0, 1'b1, 1, 5'b00000);
    add(1'b1, 1'b0, 1'b1, 8, 5'b00000);
    add(1'b1, 1'b0, 1'b1, 1, 5'b01000);
    add(1'b1, 1'b1, 1'b0, 4, 5'b01000);
    add(1'b1, 1'b1, 1'b0, 1, 5'b11100);
    add(1'b1, 1'b1, 1'b0, 1, 5'b11000);
    apply_rows("main");

    // asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check5("async reset immediate", outs, 5'b00000);
    check16("async reset inv_cnt", inv_cnt, 16'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check5("async reset held", outs, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    add(1'b1, 1'b1, 1'b0, 8, 5'b00000);
    add(1'b1, 1'b1, 1'b0, 1, 5'b11000);
    apply_rows("recover");

    // statistics: exactly ten invalid decoded samples
    add(1'b0, 1'b1, 1'b0, 1, 5'b00000);
    apply_rows("stats off");
    check16("inv_cnt in OFF", inv_cnt, 16'd0);
    add(1'b1, 1'b1, 1'b0, 8, 5'b00000);
    add(1'b1, 1'b1, 1'b0, 1, 5'b11000);
    add(1'b1, 1'b1, 1'b1, 5, 5'b11000);
    add(1'b1, 1'b1, 1'b1, 5, 5'b10001);
    add(1'b1, 1'b1, 1'b0, 4, 5'b10001);
    add(1'b1, 1'b1, 1'b0, 1, 5'b11000);
    apply_rows("stats");
    check16("inv_cnt after 10 invalid", inv_cnt, EXP_INV);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
